sysid_reader: RTL and testbench

- Avalon-MM read master that is the initiator counterpart of the system-ID slave.
- On command, it reads the ID word at address 0 and then the timestamp word at address 1.
- It compares each word against build-time expected values and reports pass/fail/timeout to the boot/health logic.
- It sits between the board-level health monitor and the sysid control_slave port.

---
 rtl/sysid_reader_pkg.sv | 33 +++
 rtl/sysid_reader_latency_ctr.sv | 61 ++++++
 rtl/sysid_reader.sv | 198 +++++++++++++++++++
 tb/tb_sysid_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_reader_pkg
//  Description : Shared types and constants for the system-ID read master.
//                The expected-value defaults are also used by the sysid
//                slave generator, so both ends agree on the build identity.
//  Revision    : 1.0 - initial release
// ============================================================================
package sysid_reader_pkg;

    // Word addresses on the sysid control_slave port
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Default build identity shared with the slave generator
    localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1457818839;

    // Width of the combined timeout/latency counter
    localparam int SYSID_TIMEOUT_W = 16;

    // Check sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_ID = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_REQ_TS = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sysid_reader_latency_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_reader_latency_ctr
//  Description : Per-read down-counters. The timeout counter is reloaded at
//                the start of each read and bounds the whole read (request
//                plus latency); the latency counter is reloaded on accept and
//                marks the cycle on which read data is valid. Both saturate
//                at zero and expose a terminal-count flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sysid_reader_latency_ctr
    import sysid_reader_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic timeout_load,
    input  logic timeout_en,
    input  logic latency_load,
    input  logic latency_en,
    output logic timeout_tc,
    output logic latency_tc
);

    // Counting down to zero gives TIMEOUT_CYCLES cycles including the load value
    localparam logic [SYSID_TIMEOUT_W-1:0] TIMEOUT_RELOAD =
        SYSID_TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    // Zero-latency builds never enter a latency state, so the reload is unused there
    localparam logic [1:0] LATENCY_RELOAD =
        (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    logic [SYSID_TIMEOUT_W-1:0] timeout_count;
    logic [1:0]                 latency_count;

    assign timeout_tc = (timeout_count == '0);
    assign latency_tc = (latency_count == 2'd0);

    // Reload has priority over decrement; both counters stop at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_count <= '0;
            latency_count <= 2'd0;
        end else begin
            if (timeout_load) begin
                timeout_count <= TIMEOUT_RELOAD;
            end else if (timeout_en && !timeout_tc) begin
                timeout_count <= timeout_count - 1'b1;
            end

            if (latency_load) begin
                latency_count <= LATENCY_RELOAD;
            end else if (latency_en && !latency_tc) begin
                latency_count <= latency_count - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysid_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_reader
//  Description : Avalon-MM read master that fetches the sysid ID word
//                (address 0) then the timestamp word (address 1), compares
//                each against build-time values and reports pass/fail/timeout
//                to the board health logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module sysid_reader
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // With zero latency the data is captured in the accept cycle itself
    localparam bit ZERO_LATENCY = (READ_LATENCY == 0);

    state_t state;
    state_t next_state;

    logic accept;
    logic timeout_load;
    logic timeout_en;
    logic latency_load;
    logic latency_en;
    logic timeout_tc;
    logic latency_tc;
    logic capture_id;
    logic capture_ts;
    logic flag_timeout;
    logic clear_flags;

    // Bus outputs decode straight from the state register so reset drops them on the same edge
    assign avm_read    = (state == ST_REQ_ID) || (state == ST_REQ_TS);
    assign avm_address = ((state == ST_REQ_TS) || (state == ST_LAT_TS)) ? SYSID_ADDR_TS
                                                                          : SYSID_ADDR_ID;
    assign busy        = (state == ST_REQ_ID) || (state == ST_LAT_ID) ||
                         (state == ST_REQ_TS) || (state == ST_LAT_TS);
    assign done        = (state == ST_FIN);
    assign accept      = avm_read && !avm_waitrequest;

    sysid_reader_latency_ctr #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_latency_ctr (
        .clock        (clock),
        .reset        (reset),
        .timeout_load (timeout_load),
        .timeout_en   (timeout_en),
        .latency_load (latency_load),
        .latency_en   (latency_en),
        .timeout_tc   (timeout_tc),
        .latency_tc   (latency_tc)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control; capture is checked before timeout so it wins a tie
    always_comb begin
        next_state   = state;
        timeout_load = 1'b0;
        timeout_en   = 1'b0;
        latency_load = 1'b0;
        latency_en   = 1'b0;
        capture_id   = 1'b0;
        capture_ts   = 1'b0;
        flag_timeout = 1'b0;
        clear_flags  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    clear_flags  = 1'b1;
                    timeout_load = 1'b1;
                    next_state   = ST_REQ_ID;
                end
            end

            ST_REQ_ID: begin
                timeout_en = 1'b1;
                if (accept && ZERO_LATENCY) begin
                    capture_id   = 1'b1;
                    timeout_load = 1'b1;
                    next_state   = ST_REQ_TS;
                end else if (timeout_tc) begin
                    flag_timeout = 1'b1;
                    next_state   = ST_FIN;
                end else if (accept) begin
                    latency_load = 1'b1;
                    next_state   = ST_LAT_ID;
                end
            end

            ST_LAT_ID: begin
                timeout_en = 1'b1;
                latency_en = 1'b1;
                if (latency_tc) begin
                    capture_id   = 1'b1;
                    timeout_load = 1'b1;
                    next_state   = ST_REQ_TS;
                end else if (timeout_tc) begin
                    flag_timeout = 1'b1;
                    next_state   = ST_FIN;
                end
            end

            ST_REQ_TS: begin
                timeout_en = 1'b1;
                if (accept && ZERO_LATENCY) begin
                    capture_ts = 1'b1;
                    next_state = ST_FIN;
                end else if (timeout_tc) begin
                    flag_timeout = 1'b1;
                    next_state   = ST_FIN;
                end else if (accept) begin
                    latency_load = 1'b1;
                    next_state   = ST_LAT_TS;
                end
            end

            ST_LAT_TS: begin
                timeout_en = 1'b1;
                latency_en = 1'b1;
                if (latency_tc) begin
                    capture_ts = 1'b1;
                    next_state = ST_FIN;
                end else if (timeout_tc) begin
                    flag_timeout = 1'b1;
                    next_state   = ST_FIN;
                end
            end

            ST_FIN: begin
                next_state = ST_IDLE;
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Result registers: compare is registered with the capture, values persist across checks
    always_ff @(posedge clock) begin
        if (reset) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if (clear_flags) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (capture_id) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (capture_ts) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            end
            if (flag_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysid_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sysid_reader
//  Description : Self-checking bench for sysid_reader. Three builds are
//                instantiated: default (latency 0), READ_LATENCY=2 and
//                TIMEOUT_CYCLES=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_reader;

    localparam logic [31:0] TS_GOOD = 32'd1457818839;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int   checks;
    int   fails;

    // ---------------- build A: default parameters ----------------
    logic        start_a, wait_a;
    logic [31:0] rdata_a, id_word_a, ts_word_a;
    logic        read_a, addr_a, busy_a, done_a, id_ok_a, ts_ok_a, to_a;
    logic [31:0] idv_a, tsv_a;
    assign rdata_a = addr_a ? ts_word_a : id_word_a;

    sysid_reader u_dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .avm_address(addr_a), .avm_read(read_a),
        .avm_waitrequest(wait_a), .avm_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a),
        .timeout(to_a), .id_value(idv_a), .ts_value(tsv_a)
    );

    // ---------------- build B: READ_LATENCY = 2 ----------------
    logic        start_b, wait_b;
    logic [31:0] rdata_b;
    logic        read_b, addr_b, busy_b, done_b, id_ok_b, ts_ok_b, to_b;
    logic [31:0] idv_b, tsv_b;

    sysid_reader #(.READ_LATENCY(2)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .avm_address(addr_b), .avm_read(read_b),
        .avm_waitrequest(wait_b), .avm_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b),
        .timeout(to_b), .id_value(idv_b), .ts_value(tsv_b)
    );

    // ---------------- build C: TIMEOUT_CYCLES = 8 ----------------
    logic        start_c, wait_c;
    logic [31:0] rdata_c;
    logic        read_c, addr_c, busy_c, done_c, id_ok_c, ts_ok_c, to_c;
    logic [31:0] idv_c, tsv_c;
    assign rdata_c = addr_c ? TS_GOOD : 32'd0;

    sysid_reader #(.TIMEOUT_CYCLES(8)) u_dut_c (
        .clock(clock), .reset(reset), .start(start_c),
        .avm_address(addr_c), .avm_read(read_c),
        .avm_waitrequest(wait_c), .avm_readdata(rdata_c),
        .busy(busy_c), .done(done_c), .id_ok(id_ok_c), .ts_ok(ts_ok_c),
        .timeout(to_c), .id_value(idv_c), .ts_value(tsv_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Directed vectors for build A
    typedef struct {
        logic [31:0] id_word;
        logic [31:0] ts_word;
        int          stall;
        bit          poke;
        logic        exp_id_ok;
        logic        exp_ts_ok;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    // Build B per-cycle slave data and expected read strobe (cycle 1 = first cycle after start)
    logic [31:0] b_data [7];
    logic        b_read [7];

    task automatic run_a(input vec_t v, input int idx);
        logic [31:0] rd_tr, ad_tr, exp_rd, exp_ad;
        int done_cyc, stalled;
        rd_tr = '0; ad_tr = '0; exp_rd = '0; exp_ad = '0;
        done_cyc = 0; stalled = 0;
        id_word_a = v.id_word;
        ts_word_a = v.ts_word;
        wait_a    = 1'b0;
        start_a   = 1'b1;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clock);
            start_a = v.poke && (cyc == 2);
            if (cyc == 1) begin
                check($sformatf("v%0d_cleared_flags", idx), {busy_a, id_ok_a, ts_ok_a, to_a}, 4'b1000);
            end
            if (read_a) rd_tr[cyc] = 1'b1;
            if (read_a && addr_a) ad_tr[cyc] = 1'b1;
            wait_a = 1'b0;
            if (read_a && !addr_a && stalled < v.stall) begin
                wait_a = 1'b1;
                stalled++;
            end
            if (done_a) done_cyc = cyc;
        end
        for (int k = 1; k <= v.stall + 2; k++) exp_rd[k] = 1'b1;
        exp_ad[v.stall + 2] = 1'b1;
        start_a = v.poke;
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d_id_ok", idx), id_ok_a, v.exp_id_ok);
        check($sformatf("v%0d_ts_ok", idx), ts_ok_a, v.exp_ts_ok);
        check($sformatf("v%0d_timeout", idx), to_a, 1'b0);
        check($sformatf("v%0d_id_value", idx), idv_a, v.id_word);
        check($sformatf("v%0d_ts_value", idx), tsv_a, v.ts_word);
        check($sformatf("v%0d_read_trace", idx), rd_tr, exp_rd);
        check($sformatf("v%0d_addr_trace", idx), ad_tr, exp_ad);
        @(negedge clock);
        start_a = 1'b0;
        check($sformatf("v%0d_idle_after", idx), {busy_a, done_a, read_a}, 3'b000);
    endtask

    task automatic run_b(input int stop_cyc, input string tag);
        rdata_b = 32'hDEADBEEF;
        wait_b  = 1'b0;
        start_b = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clock);
            start_b = 1'b0;
            check($sformatf("%s_read_c%0d", tag, cyc), read_b, b_read[cyc-1]);
            check($sformatf("%s_done_c%0d", tag, cyc), done_b, (cyc == 7));
            rdata_b = b_data[cyc-1];
            if (cyc == stop_cyc) begin
                reset = 1'b1;
                break;
            end
        end
        if (stop_cyc == 0) begin
            check($sformatf("%s_id_ok", tag), id_ok_b, 1'b1);
            check($sformatf("%s_ts_ok", tag), ts_ok_b, 1'b1);
            check($sformatf("%s_id_value", tag), idv_b, 32'd0);
            check($sformatf("%s_ts_value", tag), tsv_b, TS_GOOD);
            @(negedge clock);
        end
    endtask

    initial begin
        int done_cyc, rd_cnt;
        bit ts_seen;
        checks = 0; fails = 0;
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        wait_a = 1'b0; wait_b = 1'b0; wait_c = 1'b0;
        id_word_a = '0; ts_word_a = '0; rdata_b = '0;

        //               id_word       ts_word        stall poke id  ts  done
        vecs[0] = '{32'd0,         TS_GOOD,        0,   1'b0, 1'b1, 1'b1, 3};
        vecs[1] = '{32'd0,         32'd1457818838, 0,   1'b0, 1'b1, 1'b0, 3};
        vecs[2] = '{32'd0,         TS_GOOD,        5,   1'b1, 1'b1, 1'b1, 8};
        vecs[3] = '{32'd1,         TS_GOOD,        0,   1'b0, 1'b0, 1'b1, 3};
        vecs[4] = '{32'h8000_0000, 32'd0,          0,   1'b1, 1'b0, 1'b0, 3};

        b_data = '{32'hDEAD0000, 32'hDEAD0001, 32'd0, 32'hDEAD0003,
                   32'hDEAD0004, TS_GOOD, 32'hDEAD0006};
        b_read = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state of every build
        repeat (3) @(negedge clock);
        check("reset_ctl_a", {read_a, addr_a, busy_a, done_a, id_ok_a, ts_ok_a, to_a}, 7'd0);
        check("reset_val_a", idv_a | tsv_a, 32'd0);
        check("reset_ctl_b", {read_b, addr_b, busy_b, done_b, id_ok_b, ts_ok_b, to_b}, 7'd0);
        check("reset_ctl_c", {read_c, addr_c, busy_c, done_c, id_ok_c, ts_ok_c, to_c}, 7'd0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven checks on the default build
        for (int i = 0; i < 5; i++) run_a(vecs[i], i);

        // Timeout with waitrequest stuck high
        wait_c = 1'b1;
        start_c = 1'b1;
        done_cyc = 0; rd_cnt = 0; ts_seen = 1'b0;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clock);
            start_c = 1'b0;
            if (read_c) rd_cnt++;
            if (read_c && addr_c) ts_seen = 1'b1;
            if (done_c) done_cyc = cyc;
        end
        check("to_read_cycles", rd_cnt, 8);
        check("to_done_cycle", done_cyc, 9);
        check("to_flags", {to_c, id_ok_c, ts_ok_c}, 3'b100);
        check("to_no_ts_read", ts_seen, 1'b0);
        repeat (3) @(negedge clock);
        check("to_held", {to_c, busy_c}, 2'b10);

        // Same build recovers with a responsive slave
        wait_c = 1'b0;
        start_c = 1'b1;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clock);
            start_c = 1'b0;
            if (done_c) done_cyc = cyc;
        end
        check("to_recover_done", done_cyc, 3);
        check("to_recover_flags", {to_c, id_ok_c, ts_ok_c}, 3'b011);
        @(negedge clock);

        // Latency 2: only the +2 data after each accept is captured
        run_b(0, "lat");

        // Reset during LAT_TS (cycle 5), then a clean check
        run_b(5, "rst");
        @(negedge clock);
        check("rst_ctl", {read_b, addr_b, busy_b, done_b, id_ok_b, ts_ok_b, to_b}, 7'd0);
        check("rst_id_value", idv_b, 32'd0);
        check("rst_ts_value", tsv_b, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        run_b(0, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
